fp_multicycle_sequencer: RTL and testbench



---
 rtl/rv_pkg.sv | 29 ++
 rtl/fp_lat_counter.sv | 31 +++
 rtl/fp_multicycle_sequencer.sv | 148 ++++++++++++++
 tb/tb_fp_multicycle_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared encodings for the RV64IF multi-cycle FP sequencing logic.
// No logic: op codes, sequencer state codes, default unit latencies,
// and the control-word bit that flags a decoded op as multi-cycle.
package rv_pkg;

    // FP multi-cycle unit op select
    typedef enum logic [1:0] {
        FPOP_MUL  = 2'b00,
        FPOP_DIV  = 2'b01,
        FPOP_SQRT = 2'b10,
        FPOP_RSV  = 2'b11
    } fpop_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_WB   = 2'b10
    } seq_state_e;

    // Default occupancy of the shared FP unit, in cycles
    localparam int DEF_MUL_LAT  = 4;
    localparam int DEF_DIV_LAT  = 12;
    localparam int DEF_SQRT_LAT = 16;

    // Decoded control word bit marking an op as multi-cycle
    localparam int CTRL_MC_BIT = 23;

endpackage

// File: rtl/fp_lat_counter.sv
// Loadable down-counter timing how long the FP unit stays busy.
// Latency: load/decrement take effect at the next rising edge; zero is combinational.
// Backpressure: none; holds its value when neither load nor dec is asserted.
//
// Ports: clk, rst_n (async active-low), load + load_val, dec,
//        cnt (current value), zero (cnt == 0).
module fp_lat_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fp_multicycle_sequencer.sv
// Sequences FMUL/FDIV/FSQRT on the shared FP unit beside EX and issues one writeback.
// Latency: accept edge + LAT cycles in RUN, then one WB cycle (stall = LAT+1 when WB port free).
// Backpressure: stalls IF/ID/EX while busy; WB waits on in_wb_ready holding the stall.
//
// Ports: in_clk/in_rst_n clock and async active-low reset;
//        in_valid/in_op/in_rd/in_flush from EX; in_wb_ready from the FP writeback port;
//        out_stall (comb), out_unit_start/out_unit_abort (registered pulses), out_unit_op,
//        out_wb_en (comb)/out_wb_rd, out_busy, out_stall_cnt (saturating stall cycles).
module fp_multicycle_sequencer
    import rv_pkg::*;
#(
    parameter int MUL_LAT  = DEF_MUL_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int SQRT_LAT = DEF_SQRT_LAT,
    parameter int CNT_W    = 5,
    parameter int PERF_W   = 32
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_valid,
    input  logic [1:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic              in_flush,
    input  logic              in_wb_ready,
    output logic              out_stall,
    output logic              out_unit_start,
    output logic [1:0]        out_unit_op,
    output logic              out_unit_abort,
    output logic              out_wb_en,
    output logic [4:0]        out_wb_rd,
    output logic              out_busy,
    output logic [PERF_W-1:0] out_stall_cnt
);

    // Counter is loaded with LAT-1 so that RUN lasts exactly LAT cycles:
    // the cycle that sees zero is the last RUN cycle.
    function automatic logic [CNT_W-1:0] lat_m1(input logic [1:0] op);
        logic [CNT_W-1:0] v;
        v = '0;
        case (op)
            FPOP_MUL:  v = CNT_W'(MUL_LAT - 1);
            FPOP_DIV:  v = CNT_W'(DIV_LAT - 1);
            FPOP_SQRT: v = CNT_W'(SQRT_LAT - 1);
            default:   v = '0;   // reserved op occupies the unit one cycle
        endcase
        return v;
    endfunction

    seq_state_e       state, state_nxt;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             start_nxt, abort_nxt;
    logic             stall_raw, wb_en_raw;
    logic             start_q, abort_q;
    logic [1:0]       op_q;
    logic [4:0]       rd_q;
    logic [PERF_W-1:0] stall_cnt_q;

    fp_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk      (in_clk),
        .rst_n    (in_rst_n),
        .load     (cnt_load),
        .load_val (lat_m1(in_op)),
        .dec      (cnt_dec),
        .cnt      (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state       <= ST_IDLE;
            start_q     <= 1'b0;
            abort_q     <= 1'b0;
            op_q        <= '0;
            rd_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= start_nxt;
            abort_q <= abort_nxt;
            if (cnt_load) begin
                op_q <= in_op;
                rd_q <= in_rd;
            end
            if (stall_raw && (stall_cnt_q != {PERF_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        start_nxt = 1'b0;
        abort_nxt = 1'b0;
        stall_raw = 1'b0;
        wb_en_raw = 1'b0;
        case (state)
            ST_IDLE: begin
                // A flush in the same cycle kills the op before it is accepted.
                if (in_valid && !in_flush) begin
                    state_nxt = ST_RUN;
                    cnt_load  = 1'b1;
                    start_nxt = 1'b1;
                    stall_raw = 1'b1;
                end
            end
            ST_RUN: begin
                stall_raw = 1'b1;
                if (in_flush) begin
                    state_nxt = ST_IDLE;
                    abort_nxt = 1'b1;
                end else if (cnt_zero) begin
                    state_nxt = ST_WB;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WB: begin
                // Committed: flush no longer applies. Stall releases in the
                // write cycle so the pipeline advances with the write.
                wb_en_raw = in_wb_ready;
                stall_raw = !in_wb_ready;
                if (in_wb_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The IDLE-accept term of the stall depends on raw inputs; mask it with
    // reset so every output reads zero while reset is held.
    assign out_stall      = stall_raw & in_rst_n;
    assign out_wb_en      = wb_en_raw;
    assign out_unit_start = start_q;
    assign out_unit_abort = abort_q;
    assign out_unit_op    = op_q;
    assign out_wb_rd      = rd_q;
    assign out_busy       = (state != ST_IDLE);
    assign out_stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fp_multicycle_sequencer.sv
// Self-checking bench for fp_multicycle_sequencer with a writeback scoreboard.
// Latency: expects stall LAT+1 per op plus WB hold cycles.
// Backpressure: exercises in_wb_ready low in WB, flush in RUN and async reset mid-op.
module tb_fp_multicycle_sequencer;
    import rv_pkg::*;

    localparam int MUL_LAT  = 4;
    localparam int DIV_LAT  = 12;
    localparam int SQRT_LAT = 16;
    localparam int CNT_W    = 5;
    localparam int PERF_W   = 5;   // small so saturation is reachable quickly

    logic              in_clk = 1'b0;
    logic              in_rst_n;
    logic              in_valid;
    logic [1:0]        in_op;
    logic [4:0]        in_rd;
    logic              in_flush;
    logic              in_wb_ready;
    logic              out_stall;
    logic              out_unit_start;
    logic [1:0]        out_unit_op;
    logic              out_unit_abort;
    logic              out_wb_en;
    logic [4:0]        out_wb_rd;
    logic              out_busy;
    logic [PERF_W-1:0] out_stall_cnt;

    fp_multicycle_sequencer #(
        .MUL_LAT  (MUL_LAT),
        .DIV_LAT  (DIV_LAT),
        .SQRT_LAT (SQRT_LAT),
        .CNT_W    (CNT_W),
        .PERF_W   (PERF_W)
    ) dut (
        .in_clk         (in_clk),
        .in_rst_n       (in_rst_n),
        .in_valid       (in_valid),
        .in_op          (in_op),
        .in_rd          (in_rd),
        .in_flush       (in_flush),
        .in_wb_ready    (in_wb_ready),
        .out_stall      (out_stall),
        .out_unit_start (out_unit_start),
        .out_unit_op    (out_unit_op),
        .out_unit_abort (out_unit_abort),
        .out_wb_en      (out_wb_en),
        .out_wb_rd      (out_wb_rd),
        .out_busy       (out_busy),
        .out_stall_cnt  (out_stall_cnt)
    );

    always #5 in_clk = ~in_clk;

    int cyc_no = 0;
    always @(posedge in_clk) cyc_no <= cyc_no + 1;

    int total = 0;
    int bad   = 0;
    logic [4:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            FPOP_MUL:  return MUL_LAT;
            FPOP_DIV:  return DIV_LAT;
            FPOP_SQRT: return SQRT_LAT;
            default:   return 1;
        endcase
    endfunction

    // Results of the last run_op call
    int r_stall, r_start, r_abort, r_wb, r_start_cyc;

    // Called at posedge+1; drives one op and observes it until writeback
    // (or until the sequencer goes idle after a flush). Returns at posedge+1
    // of the following cycle so a new op can be driven back-to-back.
    task automatic run_op(input logic [1:0] op, input logic [4:0] rd,
                          input int hold_wb, input int flush_cyc);
        int  lat;
        bit  done;
        lat  = lat_of(op);
        done = 1'b0;
        r_stall = 0; r_start = 0; r_abort = 0; r_wb = 0; r_start_cyc = -1;
        if (flush_cyc < 0) sb_q.push_back(rd);
        in_valid    = 1'b1;
        in_op       = op;
        in_rd       = rd;
        in_flush    = 1'b0;
        in_wb_ready = (hold_wb == 0);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge in_clk);
            if (out_stall) r_stall++;
            if (out_unit_start) begin
                r_start++;
                r_start_cyc = cyc_no;
                chk("start_op", 32'(out_unit_op), 32'(op));
            end
            if (out_unit_abort) r_abort++;
            if (out_wb_en) begin
                r_wb++;
                if (sb_q.size() == 0) chk("wb_spurious", 1, 0);
                else chk("wb_rd", 32'(out_wb_rd), 32'(sb_q.pop_front()));
            end
            if (out_wb_en || (c > 0 && !out_busy)) begin
                done = 1'b1;
            end else begin
                @(posedge in_clk); #1;
                in_valid    = 1'b0;
                in_flush    = (c + 1 == flush_cyc);
                in_wb_ready = (c + 1 >= lat + 1 + hold_wb);
            end
        end
        if (!done) chk("timeout", 0, 1);
        @(posedge in_clk); #1;
        in_valid    = 1'b0;
        in_flush    = 1'b0;
        in_wb_ready = 1'b1;
    endtask

    task automatic do_reset();
        in_rst_n = 1'b0;
        repeat (2) @(posedge in_clk);
        #1 in_rst_n = 1'b1;
    endtask

    int div_start, wb_seen, busy_seen;

    initial begin
        in_rst_n    = 1'b0;
        in_valid    = 1'b0;
        in_op       = 2'b00;
        in_rd       = 5'd0;
        in_flush    = 1'b0;
        in_wb_ready = 1'b1;
        #12;
        chk("rst_busy",  32'(out_busy), 0);
        chk("rst_stall", 32'(out_stall), 0);
        chk("rst_wb_en", 32'(out_wb_en), 0);
        chk("rst_cnt",   32'(out_stall_cnt), 0);
        @(posedge in_clk); #1 in_rst_n = 1'b1;

        // MUL with writeback port free
        run_op(FPOP_MUL, 5'd7, 0, -1);
        chk("mul_stall", r_stall, 5);
        chk("mul_start", r_start, 1);
        chk("mul_wb",    r_wb, 1);
        chk("mul_abort", r_abort, 0);
        chk("mul_busy",  32'(out_busy), 0);
        chk("mul_cnt",   32'(out_stall_cnt), 5);

        // DIV then SQRT back-to-back
        do_reset();
        run_op(FPOP_DIV, 5'd3, 0, -1);
        div_start = r_start_cyc;
        chk("div_stall", r_stall, 13);
        run_op(FPOP_SQRT, 5'd9, 0, -1);
        chk("sqrt_stall", r_stall, 17);
        chk("b2b_start_gap", r_start_cyc - div_start, 14);
        chk("b2b_cnt", 32'(out_stall_cnt), 30);

        // Reserved op: one RUN cycle, still written back; counter saturates
        run_op(FPOP_RSV, 5'd21, 0, -1);
        chk("rsv_stall", r_stall, 2);
        chk("rsv_wb",    r_wb, 1);
        chk("sat_cnt",   32'(out_stall_cnt), 31);
        repeat (3) @(posedge in_clk);
        #1 chk("sat_hold", 32'(out_stall_cnt), 31);

        // DIV flushed in RUN cycle 6
        run_op(FPOP_DIV, 5'd4, 0, 6);
        chk("flush_abort", r_abort, 1);
        chk("flush_wb",    r_wb, 0);
        chk("flush_stall", r_stall, 7);
        chk("flush_busy",  32'(out_busy), 0);

        // SQRT with writeback port busy for 3 WB cycles
        run_op(FPOP_SQRT, 5'd12, 3, -1);
        chk("hold_stall", r_stall, 20);
        chk("hold_wb",    r_wb, 1);

        // Async reset in RUN cycle 4 of a DIV
        in_valid = 1'b1; in_op = FPOP_DIV; in_rd = 5'd30; in_wb_ready = 1'b1;
        @(posedge in_clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge in_clk);
        #3 in_rst_n = 1'b0;
        #1;
        chk("arst_busy",  32'(out_busy), 0);
        chk("arst_stall", 32'(out_stall), 0);
        chk("arst_start", 32'(out_unit_start), 0);
        chk("arst_abort", 32'(out_unit_abort), 0);
        chk("arst_wb_en", 32'(out_wb_en), 0);
        chk("arst_op",    32'(out_unit_op), 0);
        chk("arst_rd",    32'(out_wb_rd), 0);
        chk("arst_cnt",   32'(out_stall_cnt), 0);
        repeat (2) @(posedge in_clk);
        #1 in_rst_n = 1'b1;
        wb_seen = 0; busy_seen = 0;
        repeat (20) begin
            @(negedge in_clk);
            if (out_wb_en) wb_seen++;
            if (out_busy || out_unit_abort) busy_seen++;
        end
        chk("post_rst_wb",   wb_seen, 0);
        chk("post_rst_busy", busy_seen, 0);
        chk("post_rst_cnt",  32'(out_stall_cnt), 0);
        chk("sb_empty",      sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
